// File: rtl/oam_dma_controller.sv
// OAM DMA sequencer and CPU/memory port arbiter with the 0xFF46 DMA register and 127-byte HRAM.
// CPU port: writes are committed on the clock edge that samples cpu_wren; read data follows cpu_addr by one clock.
module oam_dma_controller #(
    parameter int CYCLES_PER_BYTE = 4,
    parameter int DMA_LEN         = 160
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_wren,
    input  logic [7:0]  cpu_data_in,
    output logic [7:0]  cpu_data_out,
    output logic [15:0] mem_addr,
    output logic        mem_wren,
    output logic [7:0]  mem_data_in,
    input  logic [7:0]  mem_data_out,
    output logic        dma_active,
    output logic [1:0]  dbg_state
);

    localparam int SUB_W = $clog2(CYCLES_PER_BYTE);
    localparam int IDX_W = (DMA_LEN > 1) ? $clog2(DMA_LEN) : 1;
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(CYCLES_PER_BYTE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DMA_LEN - 1);
    localparam logic [SUB_W-1:0] SUB_READ = SUB_W'(1);
    localparam logic [SUB_W-1:0] SUB_WRITE = SUB_W'(2);

    typedef enum logic [1:0] {S_IDLE, S_START, S_XFER} state_t;
    typedef enum logic [1:0] {RD_MEM, RD_HRAM, RD_REG, RD_BLOCK} rd_sel_t;

    state_t           state, state_next;
    rd_sel_t          rd_sel;
    logic [SUB_W-1:0] sub_cnt, sub_next;
    logic [IDX_W-1:0] byte_idx, idx_next;
    logic [7:0]       src_page, page_next;
    logic [7:0]       dma_reg;
    logic [7:0]       byte_buf;
    logic [7:0]       local_q;
    logic [7:0]       hram [0:126];

    logic        is_hram, is_dma, dma_wr;
    logic [6:0]  hram_idx;
    logic [15:0] idx_ext, src_addr, oam_addr;

    assign is_hram  = (cpu_addr >= 16'hFF80) && (cpu_addr != 16'hFFFF);
    assign is_dma   = (cpu_addr == 16'hFF46);
    assign dma_wr   = cpu_wren && is_dma;
    assign hram_idx = cpu_addr[6:0];
    assign idx_ext  = {{(16-IDX_W){1'b0}}, byte_idx};
    assign src_addr = {src_page, 8'h00} + idx_ext;
    assign oam_addr = 16'hFE00 + idx_ext;

    assign dma_active = (state != S_IDLE);
    assign dbg_state  = state;

    always_comb begin
        state_next  = state;
        sub_next    = sub_cnt;
        idx_next    = byte_idx;
        page_next   = src_page;
        mem_addr    = cpu_addr;
        mem_wren    = 1'b0;
        mem_data_in = cpu_data_in;
        case (state)
            S_IDLE: begin
                mem_wren = cpu_wren && !is_hram && !is_dma;
            end
            S_START: begin
                mem_addr    = src_addr;
                mem_data_in = byte_buf;
                if (sub_cnt == SUB_LAST) begin
                    state_next = S_XFER;
                    sub_next   = '0;
                end else begin
                    sub_next = sub_cnt + SUB_W'(1);
                end
            end
            S_XFER: begin
                mem_data_in = byte_buf;
                mem_addr    = (sub_cnt >= SUB_WRITE) ? oam_addr : src_addr;
                mem_wren    = (sub_cnt == SUB_WRITE);
                if (sub_cnt == SUB_LAST) begin
                    sub_next = '0;
                    if (byte_idx == IDX_LAST) state_next = S_IDLE;
                    else                      idx_next   = byte_idx + IDX_W'(1);
                end else begin
                    sub_next = sub_cnt + SUB_W'(1);
                end
            end
            default: state_next = S_IDLE;
        endcase
        // A register write always (re)starts the copy, even on the final sub-cycle.
        if (dma_wr) begin
            state_next = S_START;
            sub_next   = '0;
            idx_next   = '0;
            page_next  = (cpu_data_in >= 8'hE0) ? (cpu_data_in - 8'h20) : cpu_data_in;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            sub_cnt  <= '0;
            byte_idx <= '0;
            src_page <= 8'h00;
            dma_reg  <= 8'hFF;
            byte_buf <= 8'h00;
            rd_sel   <= RD_BLOCK;
        end else begin
            state    <= state_next;
            sub_cnt  <= sub_next;
            byte_idx <= idx_next;
            src_page <= page_next;
            if (dma_wr) dma_reg <= cpu_data_in;
            if (state == S_XFER && sub_cnt == SUB_READ) byte_buf <= mem_data_out;
            if (is_hram)         rd_sel <= RD_HRAM;
            else if (is_dma)     rd_sel <= RD_REG;
            else if (dma_active) rd_sel <= RD_BLOCK;
            else                 rd_sel <= RD_MEM;
        end
    end

    // HRAM and its read register survive reset by design.
    always_ff @(posedge clock) begin
        if (cpu_wren && is_hram) hram[hram_idx] <= cpu_data_in;
        if (is_dma)       local_q <= dma_reg;
        else if (is_hram) local_q <= hram[hram_idx];
    end

    always_comb begin
        case (rd_sel)
            RD_MEM:  cpu_data_out = mem_data_out;
            RD_HRAM: cpu_data_out = local_q;
            RD_REG:  cpu_data_out = local_q;
            default: cpu_data_out = 8'hFF;
        endcase
    end

endmodule
